// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state type and counter sizing helper
// for the digit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // Bits needed to count 0..n inclusive.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/serial_adder_fa_digit.sv
// fa_digit: combinational DIGIT-bit ripple adder of full-adder cells.
// Ports: x, y (D bits), cin -> sum (D bits), cout.
module fa_digit #(
  parameter int D = 1
) (
  input  logic [D-1:0] x,
  input  logic [D-1:0] y,
  input  logic         cin,
  output logic [D-1:0] sum,
  output logic         cout
);

  logic [D:0] c;

  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < D; i++) begin
      sum[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1]   = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  end

  assign cout = c[D];

endmodule

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder, DIGIT bits per clock, LSB first.
// Ports: clk, rst (sync, high), start/a/b/ci in; busy/done/s/co out.
// Optional ovf output (signed overflow) with SERIAL_ADDER_OVF_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             co
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad
    $error("serial_adder: WIDTH must be a multiple of DIGIT");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             co_q, co_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  logic [DIGIT-1:0] dsum;
  logic             dcout;
  logic [WIDTH-1:0] r_nxt;
  logic             load;

  fa_digit #(.D(DIGIT)) u_fa (
    .x   (a_q[DIGIT-1:0]),
    .y   (b_q[DIGIT-1:0]),
    .cin (c_q),
    .sum (dsum),
    .cout(dcout)
  );

  // New sum digits enter at the top; after N steps digit 0 is at the LSB.
  if (DIGIT == WIDTH) begin : g_one
    assign r_nxt = dsum;
  end else begin : g_many
    assign r_nxt = {dsum, r_q[WIDTH-1:DIGIT]};
  end

  assign load = start && (state_q == IDLE || state_q == DONE);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    s_d     = s_q;
    co_d    = co_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (load) state_d = RUN;
      end
      RUN: begin
        a_d   = a_q >> DIGIT;
        b_d   = b_q >> DIGIT;
        c_d   = dcout;
        r_d   = r_nxt;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
          s_d     = r_nxt;
          co_d    = dcout;
`ifdef SERIAL_ADDER_OVF_EN
          // carry into MSB recovered from the MSB sum bit
          ovf_d = a_q[DIGIT-1] ^ b_q[DIGIT-1]
                ^ dsum[DIGIT-1] ^ dcout;
`endif
        end
      end
      DONE: begin
        state_d = load ? RUN : IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      a_d   = a;
      b_d   = b;
      c_d   = ci;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      r_q     <= '0;
      s_q     <= '0;
      co_q    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      s_q     <= s_d;
      co_q    <= co_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign s    = s_q;
  assign co   = co_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for three serial_adder configs
// (8/1, 8/4, 3/1); ovf checked when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;

  typedef struct {
    int         u;
    logic [8:0] r;
    logic       ov;
    bit         chk_ov;
    int         due;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0;
  int nmis = 0;
  exp_t q[$];
  exp_t me;

  logic       st[3];
  logic [7:0] av[3];
  logic [7:0] bv[3];
  logic       civ[3];
  logic       bz[3];
  logic       dn[3];
  logic [7:0] s0, s1;
  logic [2:0] s2;
  logic       co0, co1, co2;
  logic [8:0] res[3];
  logic [2:0] a2, b2;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ov0, ov1, ov2;
`endif

  assign res[0] = {co0, s0};
  assign res[1] = {co1, s1};
  assign res[2] = {5'd0, co2, s2};
  assign a2 = av[2][2:0];
  assign b2 = bv[2][2:0];

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
    .clk(clk), .rst(rst), .start(st[0]),
    .a(av[0]), .b(bv[0]), .ci(civ[0]),
    .busy(bz[0]), .done(dn[0]), .s(s0), .co(co0)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ov0)
`endif
  );

  serial_adder #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
    .clk(clk), .rst(rst), .start(st[1]),
    .a(av[1]), .b(bv[1]), .ci(civ[1]),
    .busy(bz[1]), .done(dn[1]), .s(s1), .co(co1)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ov1)
`endif
  );

  serial_adder #(.WIDTH(3), .DIGIT(1)) u_w3d1 (
    .clk(clk), .rst(rst), .start(st[2]),
    .a(a2), .b(b2), .ci(civ[2]),
    .busy(bz[2]), .done(dn[2]), .s(s2), .co(co2)
`ifdef SERIAL_ADDER_OVF_EN
    , .ovf(ov2)
`endif
  );

  // Monitor: every done pulse must match the oldest expected entry,
  // including the cycle on which it was due.
  always @(negedge clk) begin
    for (int u = 0; u < 3; u++) begin
      if (dn[u] === 1'b1) begin
        nvec++;
        if (q.size() == 0) begin
          nmis++;
          $display("FAIL spurious_done u%0d: done=1 at cycle %0d, none expected",
                   u, cyc);
        end else begin
          me = q.pop_front();
          if (me.u != u || res[u] !== me.r || cyc != me.due) begin
            nmis++;
            $display("FAIL result u%0d: got {co,s}=%h cycle %0d, required u%0d {co,s}=%h cycle %0d",
                     u, res[u], cyc, me.u, me.r, me.due);
          end
`ifdef SERIAL_ADDER_OVF_EN
          if (me.chk_ov) begin
            nvec++;
            if (ov0 !== me.ov) begin
              nmis++;
              $display("FAIL ovf: got %b required %b", ov0, me.ov);
            end
          end
`endif
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [8:0] act,
                     input logic [8:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  // Issue one addition on unit u; returns at the first RUN negedge.
  task automatic go(input int u, input logic [7:0] a, input logic [7:0] b,
                    input logic c, input logic [8:0] r, input logic ov,
                    input bit chk_ov, input bit push);
    int n;
    int k;
    exp_t e;
    n = (u == 0) ? 8 : (u == 1) ? 2 : 3;
    k = 0;
    while (bz[u] !== 1'b0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (bz[u] !== 1'b0) begin
      nvec++;
      nmis++;
      $display("FAIL ready_timeout u%0d: busy=%b required 0", u, bz[u]);
    end
    st[u]  = 1'b1;
    av[u]  = a;
    bv[u]  = b;
    civ[u] = c;
    if (push) begin
      e.u = u; e.r = r; e.ov = ov; e.chk_ov = chk_ov;
      // accept at edge cyc+1, done in the (N+1)-th cycle after it
      e.due = cyc + n + 1;
      q.push_back(e);
    end
    @(negedge clk);
    st[u]  = 1'b0;
    av[u]  = ~a;
    bv[u]  = ~b;
    civ[u] = ~c;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    int sm;
    logic [6:0] v;
    for (int i = 0; i < 3; i++) begin
      st[i] = 1'b0; av[i] = '0; bv[i] = '0; civ[i] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 9'(bz[0]), 9'h0);
    chk("rst_done", 9'(dn[0]), 9'h0);
    chk("rst_sum", res[0], 9'h0);

    go(0, 8'h5A, 8'hA5, 1'b1, 9'h100, 1'b0, 1'b0, 1'b1);
    k = 0;
    while (bz[0] === 1'b1 && k < 20) begin
      k++;
      @(negedge clk);
    end
    chk("busy_cycles", 9'(k), 9'd8);
    go(0, 8'hFF, 8'h01, 1'b0, 9'h100, 1'b0, 1'b0, 1'b1);

    // start during RUN is ignored; s/co hold the previous result
    go(0, 8'h12, 8'h34, 1'b0, 9'h046, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    st[0] = 1'b1; av[0] = 8'hFF; bv[0] = 8'hFF; civ[0] = 1'b1;
    chk("hold_sum_run", res[0], 9'h100);
    @(negedge clk);
    st[0] = 1'b0;
    chk("hold_sum_run2", res[0], 9'h100);
    chk("busy_in_run", 9'(bz[0]), 9'h1);

    // reset mid-operation: aborted, no done pulse
    go(0, 8'h0F, 8'h01, 1'b0, 9'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 9'(bz[0]), 9'h0);
    chk("abort_done", 9'(dn[0]), 9'h0);
    chk("abort_sum", res[0], 9'h0);
    repeat (12) @(negedge clk);
    go(0, 8'h21, 8'h43, 1'b1, 9'h065, 1'b0, 1'b0, 1'b1);

    go(0, 8'h7F, 8'h01, 1'b0, 9'h080, 1'b1, 1'b1, 1'b1);
    go(0, 8'h80, 8'h80, 1'b0, 9'h100, 1'b1, 1'b1, 1'b1);
    go(0, 8'h10, 8'h20, 1'b0, 9'h030, 1'b0, 1'b1, 1'b1);

    k = 0;
    while (q.size() != 0 && k < 30) begin
      @(negedge clk);
      k++;
    end

    // DIGIT=4: second accept lands in the DONE cycle of the first
    go(1, 8'h3C, 8'h0F, 1'b0, 9'h04B, 1'b0, 1'b0, 1'b1);
    go(1, 8'hA7, 8'h6B, 1'b1, 9'h113, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 128; i++) begin
      v  = 7'(i);
      sm = int'(v[5:3]) + int'(v[2:0]) + int'(v[6]);
      go(2, {5'd0, v[5:3]}, {5'd0, v[2:0]}, v[6],
         9'(sm), 1'b0, 1'b0, 1'b1);
    end

    k = 0;
    while (q.size() != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    nvec++;
    if (q.size() != 0) begin
      nmis++;
      $display("FAIL drain: %0d results outstanding, required 0", q.size());
    end
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
